// File: rtl/cart_autodetect.sv
`timescale 1ns/1ps
// cart_autodetect: snoops the HPS ROM download stream and derives the 2600 bank-switch
// scheme, SuperChip enable and ROM size, flagged valid once the download has ended.
module cart_autodetect #(
   parameter int ADDR_W  = 17,
   parameter int SIG_MIN = 2
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              ioctl_download,
   input  logic              ioctl_wr,
   input  logic [ADDR_W-1:0] ioctl_addr,
   input  logic [7:0]        ioctl_dout,
   input  logic [23:0]       ext,
   input  logic [1:0]        sc_mode,
   output logic [3:0]        force_bs,
   output logic              sc,
   output logic [ADDR_W-1:0] rom_size,
   output logic              valid
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DECIDE, S_DONE} state_t;

   localparam logic [ADDR_W-1:0] SZ_8K     = ADDR_W'(8192);
   localparam logic [ADDR_W-1:0] SZ_12K    = ADDR_W'(12288);
   localparam logic [ADDR_W-1:0] SZ_16K    = ADDR_W'(16384);
   localparam logic [ADDR_W-1:0] SZ_32K    = ADDR_W'(32768);
   localparam logic [7:0]        SIG_MIN_B = 8'(SIG_MIN);

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_dl_prev;
   logic [7:0]        r_b1;
   logic [7:0]        r_b0;
   logic [7:0]        r_ref;
   logic [7:0]        r_cnt_e0;
   logic [7:0]        r_cnt_3f;
   logic [7:0]        r_cnt_fe;
   logic              r_sc_clean;
   logic [3:0]        r_force_bs;
   logic              r_sc;
   logic [ADDR_W-1:0] r_rom_size;
   logic              r_valid;

   logic              w_rise;
   logic              w_fall;
   logic              w_wr_load;
   logic              w_decide;
   logic              w_hit_e0;
   logic              w_hit_3f;
   logic              w_hit_fe;
   logic [ADDR_W:0]   w_addr_p1;
   logic [ADDR_W-1:0] w_size_cand;
   logic [3:0]        w_ext_bs;
   logic [3:0]        w_bs_dec;
   logic              w_sc_dec;

   assign w_rise    = ioctl_download & ~r_dl_prev;
   assign w_fall    = ~ioctl_download & r_dl_prev;
   assign w_wr_load = ioctl_wr && (r_state == S_LOAD);
   assign w_decide  = (r_state == S_DECIDE) && (w_state_nxt == S_DONE);

   // The post-shift window is {r_b1, r_b0, ioctl_dout}, so only two history bytes are kept.
   assign w_hit_e0 = (r_b1 == 8'h8D) && (r_b0[7:3] == 5'b11100) &&
                     ((ioctl_dout == 8'h1F) || (ioctl_dout == 8'hFF));
   assign w_hit_3f = (r_b0 == 8'h85) && (ioctl_dout == 8'h3F);
   assign w_hit_fe = (r_b1 == 8'h20) && (r_b0 == 8'h00) && (ioctl_dout == 8'hD0);

   assign w_addr_p1   = {1'b0, ioctl_addr} + {{ADDR_W{1'b0}}, 1'b1};
   assign w_size_cand = w_addr_p1[ADDR_W] ? '1 : w_addr_p1[ADDR_W-1:0];

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         // Reset treats the strobe as already high so a download in flight cannot resume.
         r_dl_prev <= 1'b1;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state   <= w_state_nxt;
         r_dl_prev <= ioctl_download;
      end
   end

   always_comb begin
      // NOTE: the default first means every path assigns w_state_nxt, so no latch is inferred.
      w_state_nxt = r_state;
      case (r_state)
         S_LOAD:   if (w_fall) w_state_nxt = S_DECIDE;
         S_DECIDE: w_state_nxt = S_DONE;
         default:  w_state_nxt = r_state;
      endcase
      if (w_rise) w_state_nxt = S_LOAD;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         r_b1       <= 8'h00;
         r_b0       <= 8'h00;
         r_ref      <= 8'h00;
         r_cnt_e0   <= 8'h00;
         r_cnt_3f   <= 8'h00;
         r_cnt_fe   <= 8'h00;
         r_sc_clean <= 1'b0;
         r_force_bs <= 4'd0;
         r_sc       <= 1'b0;
         r_rom_size <= '0;
         r_valid    <= 1'b0;
      end else if (w_rise) begin
         r_b1       <= 8'h00;
         r_b0       <= 8'h00;
         r_cnt_e0   <= 8'h00;
         r_cnt_3f   <= 8'h00;
         r_cnt_fe   <= 8'h00;
         r_sc_clean <= 1'b1;
         r_force_bs <= 4'd0;
         r_sc       <= 1'b0;
         r_rom_size <= '0;
         r_valid    <= 1'b0;
      end else if (w_wr_load) begin
         r_b1 <= r_b0;
         r_b0 <= ioctl_dout;
         if (w_size_cand > r_rom_size) r_rom_size <= w_size_cand;
         if (w_hit_e0 && (r_cnt_e0 != 8'hFF)) r_cnt_e0 <= r_cnt_e0 + 8'd1;
         if (w_hit_3f && (r_cnt_3f != 8'hFF)) r_cnt_3f <= r_cnt_3f + 8'd1;
         if (w_hit_fe && (r_cnt_fe != 8'hFF)) r_cnt_fe <= r_cnt_fe + 8'd1;
         // SuperChip images mirror the first page of each 4 KB bank as all one value.
         if (ioctl_addr[11:0] == 12'h000) begin
            r_ref <= ioctl_dout;
         end else if ((ioctl_addr[11:8] == 4'h0) && (ioctl_dout != r_ref)) begin
            r_sc_clean <= 1'b0;
         end
      end else if (w_decide) begin
         r_force_bs <= w_bs_dec;
         r_sc       <= w_sc_dec;
         r_valid    <= 1'b1;
      end
   end

   always_comb begin
      w_ext_bs = 4'd0;
      case (ext)
         ".F8":   w_ext_bs = 4'd1;
         ".F6":   w_ext_bs = 4'd2;
         ".FE":   w_ext_bs = 4'd3;
         ".E0":   w_ext_bs = 4'd4;
         ".3F":   w_ext_bs = 4'd5;
         ".F4":   w_ext_bs = 4'd6;
         ".P2":   w_ext_bs = 4'd7;
         ".FA":   w_ext_bs = 4'd8;
         ".CV":   w_ext_bs = 4'd9;
         default: w_ext_bs = 4'd0;
      endcase

      w_bs_dec = 4'd0;
      if (w_ext_bs != 4'd0) begin
         w_bs_dec = w_ext_bs;
      end else if ((r_cnt_e0 >= SIG_MIN_B) && (r_rom_size == SZ_8K)) begin
         w_bs_dec = 4'd4;
      end else if ((r_cnt_3f >= SIG_MIN_B) && (r_rom_size >= SZ_8K)) begin
         w_bs_dec = 4'd5;
      end else if ((r_cnt_fe != 8'h00) && (r_rom_size == SZ_8K)) begin
         w_bs_dec = 4'd3;
      end else begin
         case (r_rom_size)
            SZ_8K:   w_bs_dec = 4'd1;
            SZ_12K:  w_bs_dec = 4'd8;
            SZ_16K:  w_bs_dec = 4'd2;
            SZ_32K:  w_bs_dec = 4'd6;
            default: w_bs_dec = 4'd0;
         endcase
      end

      case (sc_mode)
         2'd1:    w_sc_dec = 1'b0;
         2'd2:    w_sc_dec = 1'b1;
         default: w_sc_dec = r_sc_clean && (r_rom_size >= SZ_8K);
      endcase
   end

   assign force_bs = r_force_bs;
   assign sc       = r_sc;
   assign rom_size = r_rom_size;
   assign valid    = r_valid;

endmodule
